// File: rtl/isqrt_pipe.sv
// Pipelined unsigned integer square root, y = floor(sqrt(x)), restoring digit-by-digit
// recurrence with 16/n_pipe_stages result bits resolved combinationally per register stage.
module isqrt_pipe #(
  parameter int n_pipe_stages = 16  // legal: 1, 2, 4, 8, 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  localparam int ITERS = 16 / n_pipe_stages;
  localparam int BITS  = 2 * ITERS;

  // One recurrence step on {rem[17:0], root[15:0]} consuming the next radicand bit pair.
  // rem stays <= 2*root, so the shifted remainder always fits 18 bits, even for x=0xFFFFFFFF.
  function automatic logic [33:0] sqrt_step(input logic [33:0] st, input logic [1:0] pair);
    logic [19:0] sh;
    logic [19:0] trial;
    sh    = {st[33:16], pair};
    trial = {2'b00, st[15:0], 2'b01};
    if (sh >= trial) begin
      return {18'(sh - trial), st[14:0], 1'b1};
    end else begin
      return {sh[17:0], st[14:0], 1'b0};
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < n_pipe_stages; gi++) begin : g_stage
      localparam int RIN = 32 - BITS * gi;  // radicand bits not yet consumed

      logic            vld_in;
      logic [17:0]     rem_in;
      logic [15:0]     root_in;
      logic [RIN-1:0]  rad_in;
      logic [33:0]     st_d;
      logic            vld_q;
      logic [15:0]     root_q;

      if (gi == 0) begin : g_head
        assign vld_in  = x_vld;
        assign rem_in  = '0;
        assign root_in = '0;
        assign rad_in  = x;
      end else begin : g_body
        assign vld_in  = g_stage[gi-1].vld_q;
        assign rem_in  = g_stage[gi-1].g_fwd.rem_q;
        assign root_in = g_stage[gi-1].root_q;
        assign rad_in  = g_stage[gi-1].g_fwd.rad_q;
      end

      always_comb begin
        st_d = {rem_in, root_in};
        for (int j = 0; j < ITERS; j++) begin
          st_d = sqrt_step(st_d, rad_in[RIN-1-2*j -: 2]);
        end
      end

      // Valid travels on its own reset path; data registers load freely.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= vld_in;
        end
      end

      always_ff @(posedge clk) begin
        root_q <= st_d[15:0];
      end

      // The final stage only needs the root; remainder and leftover radicand stop here.
      if (gi < n_pipe_stages - 1) begin : g_fwd
        logic [17:0]          rem_q;
        logic [RIN-BITS-1:0]  rad_q;
        always_ff @(posedge clk) begin
          rem_q <= st_d[33:16];
          rad_q <= rad_in[RIN-BITS-1:0];
        end
      end
    end
  endgenerate

  assign y_vld = g_stage[n_pipe_stages-1].vld_q;
  assign y     = g_stage[n_pipe_stages-1].root_q;

endmodule

// File: tb/tb_isqrt_pipe.sv
// Self-checking bench for isqrt_pipe: directed vectors plus a randomized run, applied
// simultaneously to instances with 1, 2, 4, 8 and 16 pipeline stages.
module tb_isqrt_pipe;

  localparam int NDUT = 5;
  localparam int MAXC = 8192;

  logic        clk;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic        yv [NDUT];
  logic [15:0] yy [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc    = -1;
  bit          hv [MAXC];
  logic [15:0] hy [MAXC];

  isqrt_pipe #(.n_pipe_stages(16)) dut (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(yv[4]), .y(yy[4])
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      isqrt_pipe #(.n_pipe_stages(1 << gi)) u_dut (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(yv[gi]), .y(yy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: binary search on the root.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return 16'(lo);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output of a DUT with latency L seen after edge c belongs to the request sampled at c-L+1.
  task automatic check_outputs();
    for (int p = 0; p < NDUT; p++) begin
      int lat;
      int src;
      bit ev;
      lat = 1 << p;
      src = cyc - lat + 1;
      ev  = (src >= 0) ? hv[src] : 1'b0;
      chk($sformatf("dut%0d_vld@%0d", lat, cyc), 32'(yv[p]), 32'(ev));
      if (ev) begin
        chk($sformatf("dut%0d_y@%0d", lat, cyc), 32'(yy[p]), 32'(hy[src]));
        if (p == NDUT - 1)
          $display("cycle %0d: dut16 result y=%0d (expected %0d)", cyc, yy[p], hy[src]);
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] xv, input logic [15:0] ye);
    x_vld = v;
    x     = xv;
    @(posedge clk);
    #1;
    cyc++;
    hv[cyc] = v && rst;
    hy[cyc] = ye;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 16'd0);
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b0;
    #1;
    for (int p = 0; p < NDUT; p++) chk("rst_async_vld", 32'(yv[p]), 32'd0);
    for (int i = 0; i <= cyc; i++) hv[i] = 1'b0;
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 16'd0);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] sq_x [20];
    int dens;
    logic [31:0] xv;
    logic [15:0] q;

    rst   = 1'b1;
    x_vld = 1'b0;
    x     = '0;
    #2;
    reset_pulse(3);

    // Single requests with hand-computed roots
    cycle(1'b1, 32'd0, 16'd0);          idle(20);
    cycle(1'b1, 32'd1, 16'd1);          idle(20);
    cycle(1'b1, 32'd15, 16'd3);         idle(20);
    cycle(1'b1, 32'd16, 16'd4);         idle(20);
    cycle(1'b1, 32'hFFFF_FFFF, 16'hFFFF); idle(20);
    cycle(1'b1, 32'hFFFE_0001, 16'hFFFF); idle(20);

    // Streaming perfect squares
    for (int k = 0; k < 20; k++) sq_x[k] = 32'(k * k);
    for (int k = 0; k < 20; k++) cycle(1'b1, sq_x[k], 16'(k));
    idle(20);

    // Gapped valid pattern
    cycle(1'b1, 32'd100, 16'd10);
    cycle(1'b0, $urandom, 16'd0);
    cycle(1'b0, $urandom, 16'd0);
    cycle(1'b1, 32'd99, 16'd9);
    cycle(1'b1, 32'd101, 16'd10);
    cycle(1'b0, $urandom, 16'd0);
    cycle(1'b1, 32'd400, 16'd20);
    idle(20);

    // Reset while requests are in flight; they must vanish
    cycle(1'b1, 32'd25, 16'd5);
    cycle(1'b1, 32'd36, 16'd6);
    cycle(1'b1, 32'd49, 16'd7);
    cycle(1'b1, 32'd64, 16'd8);
    cycle(1'b1, 32'd81, 16'd9);
    idle(3);
    reset_pulse(2);
    idle(2);
    cycle(1'b1, 32'd144, 16'd12);
    idle(20);

    // Randomized run with varying valid density and square-boundary values
    for (int blk = 0; blk < 6; blk++) begin
      dens = $urandom_range(5, 100);
      for (int i = 0; i < 500; i++) begin
        q = 16'($urandom_range(1, 65535));
        case ($urandom_range(0, 7))
          0:       xv = 32'(q) * 32'(q);
          1:       xv = 32'(q) * 32'(q) - 32'd1;
          default: xv = $urandom;
        endcase
        cycle(($urandom_range(1, 100) <= dens) ? 1'b1 : 1'b0, xv, ref_sqrt(xv));
      end
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
